// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It keeps a word-aligned fetch pointer (pc),
// requests instruction words from the instruction memory, and fills the
// IF/ID pipeline register (instr, pc_plus4, instr_valid). When decode stalls
// while a word is already on its way back, a one-entry skid buffer catches
// that word. A taken branch of the instruction in IF/ID redirects fetch. If a
// memory request is still outstanding at that point, the unit waits for its
// acknowledge and throws the returned word away before it moves to the target.
//
// Ports
//   clk            in   1   single clock, rising edge
//   rst            in   1   synchronous, active-high reset
//   stall          in   1   decode cannot accept a new instruction
//   branch         in   1   taken branch for the instruction in IF/ID
//   branch_offset  in  16   signed word offset of the IF/ID instruction
//   imem_ack       in   1   imem_rdata is valid this cycle
//   imem_rdata     in  32   instruction word from memory
//   imem_req       out  1   fetch request, imem_addr stable until imem_ack
//   imem_addr      out 32   byte address of the requested word (= pc)
//   instr          out 32   IF/ID instruction register
//   opcode         out  6   instr[31:26]
//   pc_plus4       out 32   IF/ID: fetch address of instr plus 4
//   instr_valid    out  1   instr is live (0 = bubble)
//   dbg_state      out  2   current FSM state (0 FETCH, 1 HOLD, 2 DROP)
//
// Handshakes
//   Memory side: a request is outstanding while imem_req=1. imem_addr does
//   not change until a cycle with imem_ack=1 completes the request.
//   Decode side: IF/ID presents instr_valid as "valid" and ~stall as
//   "ready". An instruction is consumed on a rising edge where both are 1.
//   While stall=1 a valid IF/ID entry is held unchanged.
// -----------------------------------------------------------------------------
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] branch_offset,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic [1:0]  dbg_state
);

    // FETCH: request outstanding, returned words go to IF/ID or the skid.
    // HOLD : skid buffer full, no request, waiting for decode to drain.
    // DROP : request outstanding whose data must be discarded (the branch
    //        target is parked in target_q until the acknowledge arrives).
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target_q;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic        skid_valid;

    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc_seq;

    // A branch is only meaningful for a live instruction in IF/ID.
    assign branch_taken  = branch && instr_valid;

    // The word offset is shifted to bytes. The add wraps modulo 2^32.
    assign branch_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};

    assign pc_seq        = pc + 32'd4;

    assign imem_addr     = pc;
    assign opcode        = instr[31:26];
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            imem_req    <= 1'b0;
            pc          <= 32'd0;
            target_q    <= 32'd0;
            instr       <= 32'd0;
            pc_plus4    <= 32'd0;
            instr_valid <= 1'b0;
            skid_instr  <= 32'd0;
            skid_pc4    <= 32'd0;
            skid_valid  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        skid_valid  <= 1'b0;
                        imem_req    <= 1'b1;
                        if (imem_ack) begin
                            // The returned word belongs to the wrong path.
                            // Drop it and go straight to the target.
                            pc    <= branch_target;
                            state <= S_FETCH;
                        end else begin
                            // The request must complete at its old address first.
                            target_q <= branch_target;
                            state    <= S_DROP;
                        end
                    end else if (imem_ack) begin
                        pc <= pc_seq;
                        if (stall && instr_valid) begin
                            // IF/ID is occupied and held, so park the word.
                            skid_instr <= imem_rdata;
                            skid_pc4   <= pc_seq;
                            skid_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= S_HOLD;
                        end else begin
                            // IF/ID is free, either consumed now or a bubble.
                            instr       <= imem_rdata;
                            pc_plus4    <= pc_seq;
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end else begin
                        // Nothing arrived. A consumed entry leaves a bubble.
                        if (!stall) begin
                            instr_valid <= 1'b0;
                        end
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end

                S_HOLD: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        skid_valid  <= 1'b0;
                        pc          <= branch_target;
                        imem_req    <= 1'b1;
                        state       <= S_FETCH;
                    end else if (!stall) begin
                        instr       <= skid_instr;
                        pc_plus4    <= skid_pc4;
                        instr_valid <= skid_valid;
                        skid_valid  <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_FETCH;
                    end else begin
                        imem_req <= 1'b0;
                        state    <= S_HOLD;
                    end
                end

                S_DROP: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        skid_valid  <= 1'b0;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                    end
                    imem_req <= 1'b1;
                    if (imem_ack) begin
                        // The discarded request is done. A branch taken in
                        // this same cycle wins over the parked target.
                        pc    <= branch_taken ? branch_target : target_q;
                        state <= S_FETCH;
                    end else begin
                        if (branch_taken) begin
                            target_q <= branch_target;
                        end
                        state <= S_DROP;
                    end
                end

                default: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

endmodule
